// File: rtl/v_noc_flit_sender.sv
// NoC injection stage: buffers test cases and issues flits into the router local port under per-VC credits.
// Optional: V_NOC_SENDER_TXN_ID_EN adds a wrapping txn_id counter; ENABLE_TXN_ID adds txn_id to the record.
package v_noc_sender_pkg;
  localparam int NodeID_Width     = 4;
  localparam int TxnID_Width      = 8;
  localparam int QoS_Width        = 4;
  localparam int FlitData_Width   = 32;
  localparam int VC_ID_NUM_MAX_W  = 2;
  localparam int SENDER_TIMEOUT_W = 16;
  localparam int TIMEOUT_THR_W    = 16;
  localparam int LAR_W            = 3;

  typedef struct packed {
    logic [QoS_Width-1:0]      qos_value;
    logic [NodeID_Width-1:0]   tgt_id;
    logic [NodeID_Width-1:0]   src_id;
    logic [TxnID_Width-1:0]    txn_id;
    logic [FlitData_Width-1:0] flit_data;
  } flit_t;

  localparam int FLIT_LENGTH = $bits(flit_t);

  typedef struct packed {
    logic [63:0]               mcycle_when_generated;
    logic [TIMEOUT_THR_W-1:0]  timeout_threshold;
    logic [QoS_Width-1:0]      qos_value;
    logic [NodeID_Width-1:0]   tgt_id;
    logic [NodeID_Width-1:0]   src_id;
    logic [FlitData_Width-1:0] flit_data;
  } test_case_t;

  typedef struct packed {
    logic [63:0]                  generated_mcycle;
    logic [63:0]                  sent_mcycle;
    logic [TIMEOUT_THR_W-1:0]     timeout_threshold;
    logic [QoS_Width-1:0]         qos_value;
    logic [NodeID_Width-1:0]      tgt_id;
    logic [NodeID_Width-1:0]      src_id;
    logic [FlitData_Width-1:0]    flit_data;
    logic [VC_ID_NUM_MAX_W-1:0]   inport_vc_id;
    logic [LAR_W-1:0]             look_ahead_routing;
`ifdef ENABLE_TXN_ID
    logic [TxnID_Width-1:0]       txn_id;
`endif
  } scoreboard_entry_t;
endpackage

module v_noc_flit_sender
  import v_noc_sender_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int VC_NUM      = 2,
  parameter int VC_DEPTH    = 4,
  parameter int STALL_LIMIT = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [63:0]                mcycle_i,
  input  logic                       tc_vld_i,
  output logic                       tc_rdy_o,
  input  test_case_t                 tc_i,
  output logic                       tx_flit_vld_o,
  output logic [FLIT_LENGTH-1:0]     tx_flit_o,
  output logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o,
  input  logic                       rx_credit_vld_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] rx_credit_vc_id_i,
  output logic                       sb_vld_o,
  output scoreboard_entry_t          sb_entry_o,
  output logic [31:0]                sent_cnt_o,
  output logic                       err_timeout_o,
  output logic                       err_credit_ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(VC_DEPTH + 1);
  localparam int VW = VC_ID_NUM_MAX_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

  test_case_t             fifo_mem [FIFO_DEPTH];
  test_case_t             head;
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   fifo_empty, fifo_full, push, issue, any_credit;
  logic [CW-1:0]          credit [VC_NUM];
  logic [VC_NUM-1:0]      ret_hit, take_hit;
  logic [VW-1:0]          rr, sel_vc;
  logic [TxnID_Width-1:0] txn_value;
  logic [SENDER_TIMEOUT_W-1:0] stall_cnt;
  state_t                 state_q, state_d;
  flit_t                  flit_d;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tc_rdy_o   = !fifo_full;
  assign push       = tc_vld_i && !fifo_full;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign issue      = !fifo_empty && any_credit;

  // NOTE: the buffer storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= tc_i;
  end

  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Round-robin: first VC with credit at or above rr, then wrap to those below it.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin : vc_select
    any_credit = 1'b0;
    sel_vc     = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (!any_credit && VW'(v) >= rr && credit[v] != '0) begin
        any_credit = 1'b1;
        sel_vc     = VW'(v);
      end
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (!any_credit && VW'(v) < rr && credit[v] != '0) begin
        any_credit = 1'b1;
        sel_vc     = VW'(v);
      end
    end
  end

  always_comb begin
    ret_hit  = '0;
    take_hit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      ret_hit[v]  = rx_credit_vld_i && (rx_credit_vc_id_i == VW'(v));
      take_hit[v] = issue && (sel_vc == VW'(v));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int v = 0; v < VC_NUM; v++) credit[v] <= CW'(VC_DEPTH);
      rr               <= '0;
      err_credit_ovf_o <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (ret_hit[v] && !take_hit[v]) begin
          if (credit[v] == CW'(VC_DEPTH)) err_credit_ovf_o <= 1'b1;
          else                            credit[v] <= credit[v] + 1'b1;
        end else if (take_hit[v] && !ret_hit[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
      if (issue) rr <= (sel_vc == VW'(VC_NUM - 1)) ? '0 : sel_vc + 1'b1;
    end
  end

  always_comb begin
    state_d = STALL;
    if (fifo_empty) state_d = IDLE;
    else if (issue) state_d = ACTIVE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      stall_cnt     <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == STALL) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (stall_cnt >= SENDER_TIMEOUT_W'(STALL_LIMIT - 1)) err_timeout_o <= 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

`ifdef V_NOC_SENDER_TXN_ID_EN
  logic [TxnID_Width-1:0] txn_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      txn_cnt <= '0;
    else if (issue) txn_cnt <= txn_cnt + 1'b1;
  end
  assign txn_value = txn_cnt;
`else
  assign txn_value = '0;
`endif

  always_comb begin
    flit_d.qos_value = head.qos_value;
    flit_d.tgt_id    = head.tgt_id;
    flit_d.src_id    = head.src_id;
    flit_d.txn_id    = txn_value;
    flit_d.flit_data = head.flit_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_flit_vld_o   <= 1'b0;
      tx_flit_o       <= '0;
      tx_flit_vc_id_o <= '0;
      sb_vld_o        <= 1'b0;
      sb_entry_o      <= '0;
      sent_cnt_o      <= '0;
    end else begin
      tx_flit_vld_o <= issue;
      sb_vld_o      <= issue;
      if (issue) begin
        tx_flit_o                     <= flit_d;
        tx_flit_vc_id_o               <= sel_vc;
        sb_entry_o.generated_mcycle   <= head.mcycle_when_generated;
        sb_entry_o.sent_mcycle        <= mcycle_i;
        sb_entry_o.timeout_threshold  <= head.timeout_threshold;
        sb_entry_o.qos_value          <= head.qos_value;
        sb_entry_o.tgt_id             <= head.tgt_id;
        sb_entry_o.src_id             <= head.src_id;
        sb_entry_o.flit_data          <= head.flit_data;
        sb_entry_o.inport_vc_id       <= sel_vc;
        sb_entry_o.look_ahead_routing <= '0;
`ifdef ENABLE_TXN_ID
        sb_entry_o.txn_id             <= txn_value;
`endif
        sent_cnt_o                    <= sent_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_v_noc_flit_sender.sv
// Scoreboard bench for v_noc_flit_sender: a queue/credit-count reference model checks every issued flit.
module tb_v_noc_flit_sender;
  import v_noc_sender_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int VC_NUM      = 2;
  localparam int VC_DEPTH    = 4;
  localparam int STALL_LIMIT = 20;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [63:0]                mcycle = '0;
  logic                       tc_vld_i = 1'b0;
  logic                       tc_rdy_o;
  test_case_t                 tc_i = '0;
  logic                       tx_flit_vld_o;
  logic [FLIT_LENGTH-1:0]     tx_flit_o;
  logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o;
  logic                       rx_credit_vld_i = 1'b0;
  logic [VC_ID_NUM_MAX_W-1:0] rx_credit_vc_id_i = '0;
  logic                       sb_vld_o;
  scoreboard_entry_t          sb_entry_o;
  logic [31:0]                sent_cnt_o;
  logic                       err_timeout_o;
  logic                       err_credit_ovf_o;

  v_noc_flit_sender #(
    .FIFO_DEPTH(FIFO_DEPTH), .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rstn(rstn), .mcycle_i(mcycle),
    .tc_vld_i(tc_vld_i), .tc_rdy_o(tc_rdy_o), .tc_i(tc_i),
    .tx_flit_vld_o(tx_flit_vld_o), .tx_flit_o(tx_flit_o), .tx_flit_vc_id_o(tx_flit_vc_id_o),
    .rx_credit_vld_i(rx_credit_vld_i), .rx_credit_vc_id_i(rx_credit_vc_id_i),
    .sb_vld_o(sb_vld_o), .sb_entry_o(sb_entry_o), .sent_cnt_o(sent_cnt_o),
    .err_timeout_o(err_timeout_o), .err_credit_ovf_o(err_credit_ovf_o)
  );

  always #5 clk = ~clk;
  // Edge k samples mcycle == k.
  always @(posedge clk) mcycle <= mcycle + 64'd1;

  typedef struct { longint unsigned e; int vc; } ret_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  test_case_t exp_q[$];
  ret_t       ret_q[$];
  int         cred_m [VC_NUM];
  int         rr_m;
  int         sent_m;
  bit         ovf_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    ret_q.delete();
    for (int v = 0; v < VC_NUM; v++) cred_m[v] = VC_DEPTH;
    rr_m   = 0;
    sent_m = 0;
    ovf_m  = 1'b0;
  endtask

  // Returns sampled at edges strictly before e are folded into the credit model.
  task automatic apply_returns(input longint unsigned e);
    while (ret_q.size() != 0 && ret_q[0].e < e) begin
      ret_t r;
      r = ret_q.pop_front();
      if (cred_m[r.vc] < VC_DEPTH) cred_m[r.vc]++;
      else                         ovf_m = 1'b1;
    end
  endtask

  function automatic test_case_t rand_tc();
    test_case_t t;
    t.mcycle_when_generated = {$urandom, $urandom};
    t.timeout_threshold     = TIMEOUT_THR_W'($urandom);
    t.qos_value             = QoS_Width'($urandom);
    t.tgt_id                = NodeID_Width'($urandom);
    t.src_id                = NodeID_Width'($urandom);
    t.flit_data             = $urandom;
    return t;
  endfunction

  task automatic on_issue();
    test_case_t       t;
    flit_t            f;
    int               vc;
    longint unsigned  e;
    logic [TxnID_Width-1:0] exp_txn;
    e = mcycle - 64'd1;
    apply_returns(e);
    check("flit_expected", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    t  = exp_q.pop_front();
    vc = -1;
    for (int i = 0; i < VC_NUM; i++) begin
      int v;
      v = (rr_m + i) % VC_NUM;
      if (vc < 0 && cred_m[v] > 0) vc = v;
    end
    check("vc_had_credit", vc >= 0, 1);
    if (vc >= 0) begin
      cred_m[vc]--;
      rr_m = (vc + 1) % VC_NUM;
    end
`ifdef V_NOC_SENDER_TXN_ID_EN
    exp_txn = TxnID_Width'(sent_m);
`else
    exp_txn = '0;
`endif
    sent_m++;
    f = tx_flit_o;
    check("flit_qos",      f.qos_value, t.qos_value);
    check("flit_tgt",      f.tgt_id, t.tgt_id);
    check("flit_src",      f.src_id, t.src_id);
    check("flit_txn",      f.txn_id, exp_txn);
    check("flit_data",     f.flit_data, t.flit_data);
    check("flit_vc",       tx_flit_vc_id_o, vc);
    check("sb_tgt",        sb_entry_o.tgt_id, t.tgt_id);
    check("sb_src",        sb_entry_o.src_id, t.src_id);
    check("sb_qos",        sb_entry_o.qos_value, t.qos_value);
    check("sb_data",       sb_entry_o.flit_data, t.flit_data);
    check("sb_thr",        sb_entry_o.timeout_threshold, t.timeout_threshold);
    check("sb_gen_mcycle", sb_entry_o.generated_mcycle, t.mcycle_when_generated);
    check("sb_sent_mcycle", sb_entry_o.sent_mcycle, e);
    check("sb_vc",         sb_entry_o.inport_vc_id, vc);
    check("sb_lar",        sb_entry_o.look_ahead_routing, 0);
`ifdef ENABLE_TXN_ID
    check("sb_txn",        sb_entry_o.txn_id, exp_txn);
`endif
    check("sent_cnt",      sent_cnt_o, 32'(sent_m));
  endtask

  // Monitor: decoupled from stimulus, consumes the expected queue on every issued flit.
  always @(negedge clk) begin
    if (rstn) begin
      check("sb_vld_tracks_tx", sb_vld_o, tx_flit_vld_o);
      if (tx_flit_vld_o) on_issue();
    end
  end

  task automatic do_reset();
    rstn            = 1'b0;
    tc_vld_i        = 1'b0;
    rx_credit_vld_i = 1'b0;
    #1;
    check("rst_tc_rdy",   tc_rdy_o, 1);
    check("rst_tx_vld",   tx_flit_vld_o, 0);
    check("rst_tx_flit",  tx_flit_o, 0);
    check("rst_sb_vld",   sb_vld_o, 0);
    check("rst_sb_sent",  sb_entry_o.sent_mcycle, 0);
    check("rst_sent_cnt", sent_cnt_o, 0);
    check("rst_err_to",   err_timeout_o, 0);
    check("rst_err_ovf",  err_credit_ovf_o, 0);
    model_reset();
    tick();
    rstn = 1'b1;
  endtask

  task automatic push_tc(input test_case_t tc);
    bit done = 1'b0;
    tc_i     = tc;
    tc_vld_i = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (tc_rdy_o) begin
        exp_q.push_back(tc);
        done = 1'b1;
      end
      tick();
    end
    check("push_accepted", done, 1);
  endtask

  task automatic ret_credit(input int vc);
    rx_credit_vld_i   = 1'b1;
    rx_credit_vc_id_i = VC_ID_NUM_MAX_W'(vc);
    ret_q.push_back('{e: mcycle, vc: vc});
    tick();
    rx_credit_vld_i = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_case_t tc;
    logic [63:0] k;
    model_reset();
    tick();
    do_reset();

    // Single case: accepted at edge k, visible in the cycle after edge k+1.
    tc = '0;
    tc.tgt_id = 4'd3;
    tc.src_id = 4'd1;
    tc.flit_data = 32'hA5;
    tc.mcycle_when_generated = 64'd10;
    tc_i = tc;
    tc_vld_i = 1'b1;
    k = mcycle;
    exp_q.push_back(tc);
    tick();
    tc_vld_i = 1'b0;
    check("lat_not_early", tx_flit_vld_o, 0);
    tick();
    check("lat_two_cycle", tx_flit_vld_o, 1);
    check("first_vc", tx_flit_vc_id_o, 0);
    check("first_sent_cnt", sent_cnt_o, 1);
    check("first_sent_mcycle", sb_entry_o.sent_mcycle, k + 64'd1);
    check("first_gen_mcycle", sb_entry_o.generated_mcycle, 10);
    tick();

    // Credit exhaustion, full FIFO, stall timeout, single-credit resume.
    do_reset();
    for (int i = 0; i < 12; i++) push_tc(rand_tc());
    tc_vld_i = 1'b0;
    tick(); tick();
    check("stall_sent_cnt", sent_cnt_o, 8);
    check("stall_rdy_low", tc_rdy_o, 0);
    repeat (5) tick();
    check("timeout_not_yet", err_timeout_o, 0);
    repeat (20) tick();
    check("timeout_set", err_timeout_o, 1);
    ret_credit(1);
    check("resume_not_early", tx_flit_vld_o, 0);
    tick();
    check("resume_vld", tx_flit_vld_o, 1);
    check("resume_vc1", tx_flit_vc_id_o, 1);
    tick();
    check("resume_one_only", tx_flit_vld_o, 0);
    check("resume_sent_cnt", sent_cnt_o, 9);
    check("resume_rdy", tc_rdy_o, 1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) ret_credit(i % 2);
    repeat (3) tick();
    check("stall_drained", exp_q.size(), 0);
    check("timeout_sticky", err_timeout_o, 1);
    apply_returns(mcycle);
    check("stall_ovf_model", err_credit_ovf_o, ovf_m);

    // Same-edge issue and return on a full VC0: no overflow, count unchanged.
    do_reset();
    tc = rand_tc();
    tc_i = tc;
    tc_vld_i = 1'b1;
    exp_q.push_back(tc);
    tick();
    tc_vld_i          = 1'b0;
    rx_credit_vld_i   = 1'b1;
    rx_credit_vc_id_i = '0;
    ret_q.push_back('{e: mcycle, vc: 0});
    tick();
    rx_credit_vld_i = 1'b0;
    check("overlap_vld", tx_flit_vld_o, 1);
    check("overlap_vc0", tx_flit_vc_id_o, 0);
    check("overlap_no_ovf", err_credit_ovf_o, 0);
    for (int i = 0; i < 9; i++) push_tc(rand_tc());
    tc_vld_i = 1'b0;
    repeat (4) tick();
    check("overlap_sent_cnt", sent_cnt_o, 9);
    check("overlap_pending", exp_q.size(), 1);

    // Return to a full counter: saturates and flags; sending continues.
    do_reset();
    ret_credit(0);
    check("ovf_set", err_credit_ovf_o, 1);
    apply_returns(mcycle);
    check("ovf_model", err_credit_ovf_o, ovf_m);
    for (int i = 0; i < 9; i++) push_tc(rand_tc());
    tc_vld_i = 1'b0;
    repeat (4) tick();
    check("ovf_saturated_cnt", sent_cnt_o, 8);
    check("ovf_sticky", err_credit_ovf_o, 1);

    // Reset mid-burst, then restart from a clean state.
    do_reset();
    for (int i = 0; i < 3; i++) push_tc(rand_tc());
    tc_vld_i = 1'b0;
    do_reset();
    push_tc(rand_tc());
    tc_vld_i = 1'b0;
    repeat (3) tick();
    check("post_rst_sent_cnt", sent_cnt_o, 1);

    // Randomized traffic with random credit returns.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tc = rand_tc();
      tc_i = tc;
      tc_vld_i = ($urandom_range(0, 9) < 7);
      if (tc_vld_i && tc_rdy_o) exp_q.push_back(tc);
      rx_credit_vld_i   = ($urandom_range(0, 99) < 35);
      rx_credit_vc_id_i = VC_ID_NUM_MAX_W'($urandom_range(0, VC_NUM - 1));
      if (rx_credit_vld_i) ret_q.push_back('{e: mcycle, vc: int'(rx_credit_vc_id_i)});
      tick();
    end
    tc_vld_i        = 1'b0;
    rx_credit_vld_i = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) ret_credit(i % VC_NUM);
    repeat (3) tick();
    wait_drained("rand_drained", 5);
    check("rand_sent_cnt", sent_cnt_o, 32'(sent_m));
    apply_returns(mcycle);
    check("rand_ovf_model", err_credit_ovf_o, ovf_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
